packet_sorter: RTL and testbench
================================

# packet_sorter

Parametrised streaming packet sorter for the B3 datapath: captures one packet of up to MAX_PKT_LEN words from an Avalon-ST-style sink, sorts it in place with an odd-even transposition network, and replays it on a backpressured source with sop/eop framing. Sort direction is selectable per packet. The block is a successor to the fixed-order bubble sorter. It adds ready/valid handshakes on both sides, in-band framing instead of a length input, runtime direction, and overflow truncation.

## Interface
- DWIDTH, 8: data word width.
- MAX_PKT_LEN, 16: storage depth in words. Must be ≥2. AWIDTH = $clog2(MAX_PKT_LEN)+1 is derived internally.
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, asynchronous and active-low. This is already decided.
- desc_i  in  1  sort direction: 1 = descending, 0 = ascending. Sampled on the accepted sop word.
- snk_data_i  in  DWIDTH  input word.
- snk_startofpacket_i  in  1  first word of a packet.
- snk_endofpacket_i  in  1  last word of a packet.
- snk_valid_i  in  1  input word valid.
- snk_ready_o  out  1  block accepts input.
- src_data_o  out  DWIDTH  sorted output word.
- src_startofpacket_o  out  1  first output word.
- src_endofpacket_o  out  1  last output word.
- src_valid_o  out  1  output word valid.
- src_ready_i  in  1  downstream accepts output.
- src_trunc_o  out  1  asserted together with src_endofpacket_o when the input packet exceeded MAX_PKT_LEN.

## Operation
- The FSM has four states: IDLE, WRITE, SORT, READ. A beat transfers on a clock edge where valid && ready.
- IDLE:
  - snk_ready_o = 1.
  - A beat without sop is dropped.
  - A sop beat stores the word at index 0, latches desc_i, sets len = 1 and clears trunc.
  - If that sop beat also has eop, go to SORT. Otherwise go to WRITE.
- WRITE:
  - snk_ready_o = 1.
  - Each beat is stored at index len and len increments while len < MAX_PKT_LEN.
  - Beats arriving once len == MAX_PKT_LEN are discarded and set trunc.
  - An eop beat goes to SORT.
  - A sop beat in WRITE abandons the current packet and restarts capture as in IDLE.
- SORT:
  - snk_ready_o = 0.
  - A pass counter p runs 0..len-1. Pass p compare-swaps all pairs (k, k+1) with k ≡ p mod 2 and k+1 < len, all in one cycle.
  - A pair is swapped when it is out of the latched order. Equal values are never swapped.
  - After len passes, go to READ with the read index set to 0.
- READ:
  - snk_ready_o = 0.
  - The output register presents word[idx]. sop is set when idx == 0. eop and trunc are set when idx == len-1.
  - On each output beat, idx increments.
  - On the eop beat, go to IDLE and clear len.
- Width rules: len and idx are AWIDTH bits wide, so len == MAX_PKT_LEN is representable. Comparison is unsigned.

## Timing
- Reset values:
  - snk_ready_o = 0 while rst_n_i is low, then 1 (IDLE) from the first edge after release.
  - src_valid_o, src_startofpacket_o, src_endofpacket_o, src_trunc_o = 0.
  - src_data_o = 0.
  - State = IDLE, len = 0. Storage contents are don't-care.
- Sort latency: exactly len cycles in SORT, where len is the stored count (at most MAX_PKT_LEN).
- First output: src_valid_o rises 1 cycle after SORT ends. The latency from the eop beat to the first src_valid_o is therefore len+1 cycles.
- Backpressure: while src_valid_o = 1 and src_ready_i = 0, all src_* outputs hold stable. Full throughput is 1 word/cycle when src_ready_i stays high.
- snk_ready_o rises in the cycle after the output eop beat. There is no overlap between read and capture.
- Reset asserted mid-operation clears everything asynchronously, and the packet in flight is lost.
- An input with both sop and eop on one beat is a single-word packet: 1 SORT cycle, then 1 output beat with sop = eop = 1.

## Structure
- Package sorter_pkg holds:
  - the state typedef enum (IDLE, WRITE, SORT, READ);
  - the function for the derived AWIDTH;
  - the default parameter constants.
- Sub-module cmp_swap (DWIDTH) is combinational. It takes inputs a, b, desc and produces outputs lo_o and hi_o in the requested order. It is instantiated MAX_PKT_LEN-1 times, and the parity and length masks are applied in the parent.
- The storage is a register array. RAM is not usable because every pass needs parallel access to all words.

## Test plan
- Sort descending: 16-word packet 3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3 with desc_i = 1 → output 9,9,9,8,7,6,5,5,5,4,3,3,3,2,1,1. sop on the first word, eop on the last, src_trunc_o = 0. First valid appears 17 cycles after the eop beat.
- Sort ascending: 5-word packet 0xFF,0x00,0x80,0x7F,0x01 with desc_i = 0 → output 00,01,7F,80,FF.
- Single word: sop+eop beat 0x42 → one beat 0x42 with sop = eop = 1. snk_ready_o is high again on the following cycle.
- Overflow: 20-word packet of values 20..1 with desc_i = 0 → 16 output words 5..20 in ascending order. src_trunc_o = 1 on the eop beat.
- Framing errors and backpressure:
  - a beat without sop in IDLE is dropped;
  - a mid-packet sop restarts the packet;
  - src_ready_i toggled randomly must leave the output sequence unchanged, with outputs stable while stalled.
- Async reset: assert rst_n_i mid-SORT and mid-READ → all outputs reach their reset values immediately. The next packet after release sorts correctly.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and constants for the streaming packet sorter.
package sorter_pkg;

    localparam int DEF_DWIDTH      = 8;
    localparam int DEF_MAX_PKT_LEN = 16;

    // Control states of the capture / sort / replay sequence
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SORT  = 2'd2,
        READ  = 2'd3
    } state_t;

    // Length / index width, one bit wider so a full buffer count fits
    function automatic int sorter_awidth(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange element of the odd-even transposition network.
// lo_o goes to the lower index and hi_o to the upper index of the pair.
module cmp_swap
    import sorter_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              desc,
    output logic [DWIDTH-1:0] lo_o,
    output logic [DWIDTH-1:0] hi_o
);

    logic swap;

    // Swap only when strictly out of order so equal words keep their place
    always_comb begin
        swap = desc ? (a < b) : (a > b);
        lo_o = swap ? b : a;
        hi_o = swap ? a : b;
    end

endmodule

// File: rtl/packet_sorter.sv
// Streaming packet sorter: captures one framed packet into a register
// array, sorts it with one odd-even transposition pass per cycle, then
// replays it on a backpressured source with sop/eop framing.
module packet_sorter
    import sorter_pkg::*;
#(
    parameter int DWIDTH      = DEF_DWIDTH,
    parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              desc_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              src_trunc_o
);

    localparam int AWIDTH = sorter_awidth(MAX_PKT_LEN);
    localparam int IWIDTH = $clog2(MAX_PKT_LEN);
    localparam logic [AWIDTH-1:0] LEN_MAX = AWIDTH'(MAX_PKT_LEN);
    localparam logic [AWIDTH-1:0] ONE     = AWIDTH'(1);

    state_t            state;
    logic [AWIDTH-1:0] len;
    logic [AWIDTH-1:0] pass;
    logic [AWIDTH-1:0] idx;
    logic [AWIDTH-1:0] nidx;
    logic [AWIDTH-1:0] len_last;
    logic              desc_q;
    logic              trunc_q;
    logic              ready_en;
    logic              accept;

    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
    logic [DWIDTH-1:0] nxt [MAX_PKT_LEN];
    logic [DWIDTH-1:0] lo  [MAX_PKT_LEN-1];
    logic [DWIDTH-1:0] hi  [MAX_PKT_LEN-1];
    logic [MAX_PKT_LEN-2:0] sel;

    // Sink is open only in the capture states, and never while in reset
    always_comb begin
        snk_ready_o = ready_en && ((state == IDLE) || (state == WRITE));
        accept      = snk_valid_i && snk_ready_o;
        nidx        = idx + ONE;
        len_last    = len - ONE;
    end

    // One comparator per adjacent pair; parity and length decide which act
    for (genvar k = 0; k < MAX_PKT_LEN - 1; k++) begin : g_pair
        localparam logic [AWIDTH-1:0] UPPER = AWIDTH'(k + 1);
        localparam logic              PAR   = 1'(k % 2);

        cmp_swap #(.DWIDTH(DWIDTH)) u_cmp_swap (
            .a    (mem[k]),
            .b    (mem[k+1]),
            .desc (desc_q),
            .lo_o (lo[k]),
            .hi_o (hi[k])
        );

        assign sel[k] = (pass[0] == PAR) && (UPPER < len);
    end

    // Next array contents after the current transposition pass
    always_comb begin
        nxt = mem;
        for (int k = 0; k < MAX_PKT_LEN - 1; k++) begin
            if (sel[k]) begin
                nxt[k]   = lo[k];
                nxt[k+1] = hi[k];
            end
        end
    end

    // Word storage: written by capture beats or by a whole sort pass
    always_ff @(posedge clk_i) begin
        if (state == SORT) begin
            mem <= nxt;
        end else if (accept) begin
            if (snk_startofpacket_i) begin
                mem[0] <= snk_data_i;
            end else if ((state == WRITE) && (len < LEN_MAX)) begin
                mem[len[IWIDTH-1:0]] <= snk_data_i;
            end
        end
    end

    // Sequencing of capture, sort passes and output replay
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= IDLE;
            len                 <= '0;
            pass                <= '0;
            idx                 <= '0;
            desc_q              <= 1'b0;
            trunc_q             <= 1'b0;
            ready_en            <= 1'b0;
            src_data_o          <= '0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_valid_o         <= 1'b0;
            src_trunc_o         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE, WRITE: begin
                    if (accept && snk_startofpacket_i) begin
                        desc_q  <= desc_i;
                        len     <= ONE;
                        trunc_q <= 1'b0;
                        pass    <= '0;
                        state   <= snk_endofpacket_i ? SORT : WRITE;
                    end else if (accept && (state == WRITE)) begin
                        if (len < LEN_MAX) begin
                            len <= len + ONE;
                        end else begin
                            trunc_q <= 1'b1;
                        end
                        if (snk_endofpacket_i) begin
                            pass  <= '0;
                            state <= SORT;
                        end
                    end
                end
                SORT: begin
                    if (pass == len_last) begin
                        pass  <= '0;
                        idx   <= '0;
                        state <= READ;
                    end else begin
                        pass <= pass + ONE;
                    end
                end
                READ: begin
                    if (!src_valid_o) begin
                        src_data_o          <= mem[idx[IWIDTH-1:0]];
                        src_startofpacket_o <= (idx == '0);
                        src_endofpacket_o   <= (idx == len_last);
                        src_trunc_o         <= trunc_q && (idx == len_last);
                        src_valid_o         <= 1'b1;
                    end else if (src_ready_i) begin
                        if (src_endofpacket_o) begin
                            src_valid_o         <= 1'b0;
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= 1'b0;
                            src_trunc_o         <= 1'b0;
                            len                 <= '0;
                            idx                 <= '0;
                            state               <= IDLE;
                        end else begin
                            idx                 <= nidx;
                            src_data_o          <= mem[nidx[IWIDTH-1:0]];
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= (nidx == len_last);
                            src_trunc_o         <= trunc_q && (nidx == len_last);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sorter.sv
// Scoreboard testbench for packet_sorter: stimulus pushes the expected
// sorted packet into a queue, a monitor pops and compares each output beat.
module tb_packet_sorter;

    localparam int MAX = 16;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       trunc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       desc;
    logic [7:0] snk_data;
    logic       snk_sop;
    logic       snk_eop;
    logic       snk_valid;
    logic       snk_ready;
    logic [7:0] src_data;
    logic       src_sop;
    logic       src_eop;
    logic       src_valid;
    logic       src_ready;
    logic       src_trunc;

    exp_t       exp_q[$];
    logic [7:0] stim_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         rand_ready = 0;

    packet_sorter #(.DWIDTH(8), .MAX_PKT_LEN(MAX)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .desc_i              (desc),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid),
        .snk_ready_o         (snk_ready),
        .src_data_o          (src_data),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .src_trunc_o         (src_trunc)
    );

    // Free-running clock
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: random when enabled, otherwise always accepting
    initial begin
        src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            src_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each transferred beat and checks stability while stalled
    initial begin
        bit   stalled;
        logic [11:0] held;
        exp_t e;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_hold", {20'd0, src_valid, src_sop, src_eop, src_trunc, src_data}, {20'd0, held});
                end
                if (src_valid && src_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", {24'd0, src_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("data",  {24'd0, src_data}, {24'd0, e.data});
                        checkOutput("sop",   {31'd0, src_sop},   {31'd0, e.sop});
                        checkOutput("eop",   {31'd0, src_eop},   {31'd0, e.eop});
                        checkOutput("trunc", {31'd0, src_trunc}, {31'd0, e.trunc});
                    end
                end
                stalled = src_valid && !src_ready;
                held    = {src_valid, src_sop, src_eop, src_trunc, src_data};
            end
        end
    end

    // Drive one sink beat and hold it until the DUT accepts it
    task automatic sendBeat(input logic [7:0] d, input logic s, input logic e, input logic dsc);
        int   waited;
        logic acc;
        waited    = 0;
        acc       = 1'b0;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
        desc      = dsc;
        snk_valid = 1'b1;
        while (!acc && waited < 400) begin
            @(negedge clk);
            acc = snk_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        if (!acc) checkOutput("snk_accept_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: keep the first MAX words, sort them, push framing
    task automatic applyStimulus(input logic dsc);
        logic [7:0] s[$];
        logic [7:0] t;
        int         n;
        int         keep;
        exp_t       e;
        n    = stim_q.size();
        keep = (n > MAX) ? MAX : n;
        for (int i = 0; i < keep; i++) s.push_back(stim_q[i]);
        for (int i = 1; i < keep; i++) begin
            for (int j = i; j > 0; j--) begin
                if (dsc ? (s[j-1] < s[j]) : (s[j-1] > s[j])) begin
                    t      = s[j];
                    s[j]   = s[j-1];
                    s[j-1] = t;
                end
            end
        end
        for (int i = 0; i < keep; i++) begin
            e.data  = s[i];
            e.sop   = (i == 0);
            e.eop   = (i == keep - 1);
            e.trunc = (i == keep - 1) && (n > MAX);
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) sendBeat(stim_q[i], i == 0, i == n - 1, dsc);
    endtask

    // Wait (bounded) until every expected beat has been seen
    task automatic waitDrain();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !src_valid) break;
        end
        checkOutput("drain_pending", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_snk_ready"}, {31'd0, snk_ready}, 32'd0);
        checkOutput({tag, "_src_flags"}, {28'd0, src_valid, src_sop, src_eop, src_trunc}, 32'd0);
        checkOutput({tag, "_src_data"},  {24'd0, src_data}, 32'd0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", {31'd0, snk_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] pkt_desc[16] = '{3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3};
        logic [7:0] pkt_asc[5]   = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01};
        int         n;
        int         len;
        rst_n     = 1'b0;
        desc      = 1'b0;
        snk_data  = '0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_valid = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        releaseReset();

        // Descending 16-word packet with first-valid latency
        stim_q.delete();
        foreach (pkt_desc[i]) stim_q.push_back(pkt_desc[i]);
        applyStimulus(1'b1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (src_valid) begin
                n = i;
                break;
            end
        end
        checkOutput("first_valid_latency", n, 32'd17);
        waitDrain();

        // Ascending 5-word packet, unsigned compare
        stim_q.delete();
        foreach (pkt_asc[i]) stim_q.push_back(pkt_asc[i]);
        applyStimulus(1'b0);
        waitDrain();

        // Single-word packet, sink reopens right after the output beat
        stim_q.delete();
        stim_q.push_back(8'h42);
        applyStimulus(1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (src_valid) break;
        end
        @(posedge clk);
        #1;
        checkOutput("single_ready_again", {31'd0, snk_ready}, 32'd1);
        waitDrain();

        // Overflow: 20 words 20..1 ascending, keeps 20..5
        stim_q.delete();
        for (int v = 20; v >= 1; v--) stim_q.push_back(8'(v));
        applyStimulus(1'b0);
        waitDrain();

        // Framing errors: stray beats in IDLE dropped, mid-packet sop restarts
        sendBeat(8'h55, 1'b0, 1'b0, 1'b0);
        sendBeat(8'h66, 1'b0, 1'b1, 1'b0);
        sendBeat(8'h11, 1'b1, 1'b0, 1'b1);
        sendBeat(8'h22, 1'b0, 1'b0, 1'b1);
        stim_q.delete();
        foreach (pkt_asc[i]) stim_q.push_back(pkt_asc[i]);
        applyStimulus(1'b1);
        waitDrain();

        // Random packets under random backpressure
        rand_ready = 1;
        for (int p = 0; p < 10; p++) begin
            stim_q.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) sendBeat(8'($urandom), 1'b0, 1'b0, 1'b0);
            applyStimulus(1'($urandom_range(0, 1)));
        end
        waitDrain();
        rand_ready = 0;

        // Reset in the middle of SORT
        stim_q.delete();
        foreach (pkt_desc[i]) stim_q.push_back(pkt_desc[i]);
        applyStimulus(1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkResetOutputs("sort_reset");
        releaseReset();

        // Reset in the middle of READ
        stim_q.delete();
        foreach (pkt_desc[i]) stim_q.push_back(pkt_desc[i]);
        applyStimulus(1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (src_valid) break;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkResetOutputs("read_reset");
        releaseReset();

        // Packet after reset still sorts correctly
        stim_q.delete();
        foreach (pkt_asc[i]) stim_q.push_back(pkt_asc[i]);
        applyStimulus(1'b1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
